// File: rtl/bus_xfer_ctrl_pkg.sv
// Shared types for the register-transfer bus controller.
package bus_xfer_ctrl_pkg;

  // Width of the bus-settle counter; covers SETTLE values 1..15.
  localparam int unsigned CNT_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_LATCH,
    ST_HOLD,
    ST_GAP
  } state_e;

  typedef enum logic {
    OP_MOVE = 1'b0,
    OP_ALU  = 1'b1
  } op_e;

endpackage

// File: rtl/reg_sel_decode.sv
// Index-to-one-hot register select decoder with selectable output polarity.
module reg_sel_decode #(
  parameter int unsigned NREG       = 4,
  parameter bit          ACTIVE_LOW = 1'b0,
  parameter int unsigned IDX_W      = $clog2(NREG)
) (
  input  logic [IDX_W-1:0] idx,
  input  logic             en,
  output logic [NREG-1:0]  vec
);

  logic [NREG-1:0] onehot;

  // Decode the index when enabled, then apply the requested polarity.
  always_comb begin
    onehot = '0;
    if (en) onehot[idx] = 1'b1;
    vec = ACTIVE_LOW ? ~onehot : onehot;
  end

endmodule

// File: rtl/bus_xfer_ctrl.sv
// Sequences a register-to-register bus transfer: drive source(s), settle,
// latch destination, hold source one cycle, then a break-before-make gap.
module bus_xfer_ctrl
  import bus_xfer_ctrl_pkg::*;
#(
  parameter int unsigned NREG   = 4,
  parameter int unsigned SETTLE = 1,
  parameter int unsigned IDX_W  = $clog2(NREG)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             REQ_valid,
  output logic             REQ_ready,
  input  logic             REQ_op,
  input  logic [IDX_W-1:0] REQ_src,
  input  logic [IDX_W-1:0] REQ_src2,
  input  logic [IDX_W-1:0] REQ_dst,
  output logic [NREG-1:0]  LOAD,
  output logic [NREG-1:0]  ASSERT_MAIN_bar,
  output logic [NREG-1:0]  ASSERT_LHS_bar,
  output logic [NREG-1:0]  ASSERT_RHS_bar,
  output logic             ALU_ASSERT_MAIN_bar,
  output logic             DONE,
  output logic             ERR
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  op_e              op_q, op_d;
  logic [IDX_W-1:0] src_q, src_d;
  logic [IDX_W-1:0] src2_q, src2_d;
  logic [IDX_W-1:0] dst_q, dst_d;
  logic             reject_q, reject_d;

  logic [NREG-1:0]  load_q, load_d;
  logic [NREG-1:0]  main_bar_q, main_bar_d;
  logic [NREG-1:0]  lhs_bar_q, lhs_bar_d;
  logic [NREG-1:0]  rhs_bar_q, rhs_bar_d;
  logic             alu_main_bar_q, alu_main_bar_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic             accept;
  logic             req_reject;
  logic             req_noop;
  logic             main_en, alu_en, load_en;

  assign accept     = REQ_valid && (state_q == ST_IDLE);
  assign req_reject = (REQ_op == OP_ALU) && ((REQ_dst == REQ_src) || (REQ_dst == REQ_src2));
  assign req_noop   = (REQ_op == OP_MOVE) && (REQ_src == REQ_dst);

  // Capture request fields on accept; otherwise keep the in-flight request.
  always_comb begin
    op_d     = op_q;
    src_d    = src_q;
    src2_d   = src2_q;
    dst_d    = dst_q;
    reject_d = reject_q;
    if (accept) begin
      op_d     = op_e'(REQ_op);
      src_d    = REQ_src;
      src2_d   = REQ_src2;
      dst_d    = REQ_dst;
      reject_d = req_reject;
    end
  end

  // Next-state logic; no-op and rejected requests skip straight to GAP.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (req_reject || req_noop) begin
            state_d = ST_GAP;
          end else begin
            state_d = ST_DRIVE;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      ST_DRIVE: begin
        if (cnt_q == CNT_W'(SETTLE)) state_d = ST_LATCH;
        else                         cnt_d   = cnt_q + CNT_W'(1);
      end
      ST_LATCH: state_d = ST_HOLD;
      ST_HOLD:  state_d = ST_GAP;
      ST_GAP:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Strobe enables derived from the next state so every output is a flop.
  always_comb begin
    main_en        = 1'b0;
    alu_en         = 1'b0;
    load_en        = (state_d == ST_LATCH);
    if (state_d inside {ST_DRIVE, ST_LATCH, ST_HOLD}) begin
      main_en = (op_d == OP_MOVE);
      alu_en  = (op_d == OP_ALU);
    end
    alu_main_bar_d = ~alu_en;
    done_d         = (state_d == ST_GAP) && !reject_d;
    err_d          = (state_d == ST_GAP) && reject_d;
  end

  reg_sel_decode #(.NREG(NREG), .ACTIVE_LOW(1'b0), .IDX_W(IDX_W)) u_load_dec (
    .idx (dst_d),
    .en  (load_en),
    .vec (load_d)
  );

  reg_sel_decode #(.NREG(NREG), .ACTIVE_LOW(1'b1), .IDX_W(IDX_W)) u_main_dec (
    .idx (src_d),
    .en  (main_en),
    .vec (main_bar_d)
  );

  reg_sel_decode #(.NREG(NREG), .ACTIVE_LOW(1'b1), .IDX_W(IDX_W)) u_lhs_dec (
    .idx (src_d),
    .en  (alu_en),
    .vec (lhs_bar_d)
  );

  reg_sel_decode #(.NREG(NREG), .ACTIVE_LOW(1'b1), .IDX_W(IDX_W)) u_rhs_dec (
    .idx (src2_d),
    .en  (alu_en),
    .vec (rhs_bar_d)
  );

  // State, request and strobe registers; reset forces every strobe inactive.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      op_q           <= OP_MOVE;
      src_q          <= '0;
      src2_q         <= '0;
      dst_q          <= '0;
      reject_q       <= 1'b0;
      load_q         <= '0;
      main_bar_q     <= '1;
      lhs_bar_q      <= '1;
      rhs_bar_q      <= '1;
      alu_main_bar_q <= 1'b1;
      done_q         <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      op_q           <= op_d;
      src_q          <= src_d;
      src2_q         <= src2_d;
      dst_q          <= dst_d;
      reject_q       <= reject_d;
      load_q         <= load_d;
      main_bar_q     <= main_bar_d;
      lhs_bar_q      <= lhs_bar_d;
      rhs_bar_q      <= rhs_bar_d;
      alu_main_bar_q <= alu_main_bar_d;
      done_q         <= done_d;
      err_q          <= err_d;
    end
  end

  assign REQ_ready           = (state_q == ST_IDLE);
  assign LOAD                = load_q;
  assign ASSERT_MAIN_bar     = main_bar_q;
  assign ASSERT_LHS_bar      = lhs_bar_q;
  assign ASSERT_RHS_bar      = rhs_bar_q;
  assign ALU_ASSERT_MAIN_bar = alu_main_bar_q;
  assign DONE                = done_q;
  assign ERR                 = err_q;

endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// Bench for bus_xfer_ctrl: two instances (SETTLE=1 and SETTLE=2), directed
// cases followed by random requests checked against a cycle-timeline model.
module tb_bus_xfer_ctrl;

  logic       clk = 1'b0;
  logic       rst   [2];
  logic       valid [2];
  logic       ready [2];
  logic       op    [2];
  logic [1:0] src   [2];
  logic [1:0] src2  [2];
  logic [1:0] dst   [2];
  logic [3:0] load  [2];
  logic [3:0] mbar  [2];
  logic [3:0] lbar  [2];
  logic [3:0] rbar  [2];
  logic       abar  [2];
  logic       done  [2];
  logic       err   [2];

  int passed = 0;
  int failed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  bus_xfer_ctrl #(.NREG(4), .SETTLE(1)) u_s1 (
    .CLK(clk), .RST(rst[0]), .REQ_valid(valid[0]), .REQ_ready(ready[0]),
    .REQ_op(op[0]), .REQ_src(src[0]), .REQ_src2(src2[0]), .REQ_dst(dst[0]),
    .LOAD(load[0]), .ASSERT_MAIN_bar(mbar[0]), .ASSERT_LHS_bar(lbar[0]),
    .ASSERT_RHS_bar(rbar[0]), .ALU_ASSERT_MAIN_bar(abar[0]),
    .DONE(done[0]), .ERR(err[0])
  );

  bus_xfer_ctrl #(.NREG(4), .SETTLE(2)) u_s2 (
    .CLK(clk), .RST(rst[1]), .REQ_valid(valid[1]), .REQ_ready(ready[1]),
    .REQ_op(op[1]), .REQ_src(src[1]), .REQ_src2(src2[1]), .REQ_dst(dst[1]),
    .LOAD(load[1]), .ASSERT_MAIN_bar(mbar[1]), .ASSERT_LHS_bar(lbar[1]),
    .ASSERT_RHS_bar(rbar[1]), .ALU_ASSERT_MAIN_bar(abar[1]),
    .DONE(done[1]), .ERR(err[1])
  );

  function automatic int settle_of(input int k);
    return (k == 0) ? 1 : 2;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input int k, input string tag);
    chk($sformatf("%s i%0d ready", tag, k), 32'(ready[k]), 32'd1);
    chk($sformatf("%s i%0d load",  tag, k), 32'(load[k]),  32'h0);
    chk($sformatf("%s i%0d main",  tag, k), 32'(mbar[k]),  32'hF);
    chk($sformatf("%s i%0d lhs",   tag, k), 32'(lbar[k]),  32'hF);
    chk($sformatf("%s i%0d rhs",   tag, k), 32'(rbar[k]),  32'hF);
    chk($sformatf("%s i%0d alu",   tag, k), 32'(abar[k]),  32'd1);
    chk($sformatf("%s i%0d done",  tag, k), 32'(done[k]),  32'd0);
    chk($sformatf("%s i%0d err",   tag, k), 32'(err[k]),   32'd0);
  endtask

  // Cycle count from accept until ready returns.
  function automatic int xfer_len(input int k, input logic o, input logic [1:0] s,
                                  input logic [1:0] s2, input logic [1:0] d);
    logic shortcut;
    shortcut = (o && (d == s || d == s2)) || (!o && s == d);
    return shortcut ? 2 : settle_of(k) + 4;
  endfunction

  // Expected outputs in cycle c after the accepting edge.
  task automatic check_cycle(input int k, input logic o, input logic [1:0] s,
                             input logic [1:0] s2, input logic [1:0] d, input int c);
    int         st;
    logic       rej, noop, active;
    logic [3:0] e_main, e_lhs, e_rhs, e_load;
    logic       e_done, e_err, e_ready;
    string      t;
    st      = settle_of(k);
    rej     = o && (d == s || d == s2);
    noop    = !o && (s == d);
    e_main  = 4'hF;
    e_lhs   = 4'hF;
    e_rhs   = 4'hF;
    e_load  = 4'h0;
    if (rej || noop) begin
      active  = 1'b0;
      e_done  = (c == 1) && noop;
      e_err   = (c == 1) && rej;
      e_ready = (c == 2);
    end else begin
      active  = (c >= 1) && (c <= st + 2);
      if (c == st + 1) e_load[d] = 1'b1;
      e_done  = (c == st + 3);
      e_err   = 1'b0;
      e_ready = (c == st + 4);
    end
    if (active && !o) e_main[s] = 1'b0;
    if (active && o) begin
      e_lhs[s]  = 1'b0;
      e_rhs[s2] = 1'b0;
    end
    t = $sformatf("i%0d op%0d s%0d s2%0d d%0d c%0d", k, o, s, s2, d, c);
    chk({t, " ready"}, 32'(ready[k]), 32'(e_ready));
    chk({t, " load"},  32'(load[k]),  32'(e_load));
    chk({t, " main"},  32'(mbar[k]),  32'(e_main));
    chk({t, " lhs"},   32'(lbar[k]),  32'(e_lhs));
    chk({t, " rhs"},   32'(rbar[k]),  32'(e_rhs));
    chk({t, " alu"},   32'(abar[k]),  32'(!(active && o)));
    chk({t, " done"},  32'(done[k]),  32'(e_done));
    chk({t, " err"},   32'(err[k]),   32'(e_err));
  endtask

  // Starts at a falling edge with the instance idle; ends at the falling
  // edge of the cycle where ready is back. With hold set, REQ_valid stays
  // high carrying the next request so it is accepted at the following edge.
  task automatic do_xfer(input int k, input logic o, input logic [1:0] s,
                         input logic [1:0] s2, input logic [1:0] d, input logic hold,
                         input logic no, input logic [1:0] ns, input logic [1:0] ns2,
                         input logic [1:0] nd);
    int last;
    last     = xfer_len(k, o, s, s2, d);
    valid[k] = 1'b1;
    op[k]    = o;
    src[k]   = s;
    src2[k]  = s2;
    dst[k]   = d;
    @(posedge clk);
    for (int c = 1; c <= last; c++) begin
      @(negedge clk);
      check_cycle(k, o, s, s2, d, c);
      if (c == 1) begin
        if (hold) begin
          op[k]   = no;
          src[k]  = ns;
          src2[k] = ns2;
          dst[k]  = nd;
        end else begin
          valid[k] = 1'b0;
        end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       c_op, n_op, hold;
    logic [1:0] c_s, c_s2, c_d, n_s, n_s2, n_d;
    int         gap;

    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1; valid[k] = 1'b0; op[k] = 1'b0;
      src[k] = '0; src2[k] = '0; dst[k] = '0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst[0] = 1'b0; rst[1] = 1'b0;
    check_idle(0, "por");
    check_idle(1, "por");

    // Reset held two cycles while idle.
    repeat (2) @(negedge clk);
    rst[0] = 1'b1; rst[1] = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst[0] = 1'b0; rst[1] = 1'b0;
    check_idle(0, "idle_rst");
    check_idle(1, "idle_rst");

    // Directed transfers.
    do_xfer(0, 1'b0, 2'd1, 2'd0, 2'd2, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0);
    do_xfer(1, 1'b1, 2'd0, 2'd3, 2'd2, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0);
    do_xfer(0, 1'b0, 2'd3, 2'd0, 2'd3, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0);
    do_xfer(0, 1'b1, 2'd1, 2'd2, 2'd1, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0);
    do_xfer(1, 1'b1, 2'd1, 2'd2, 2'd2, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0);
    do_xfer(1, 1'b1, 2'd2, 2'd2, 2'd0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0);

    // Back-to-back MOVEs with REQ_valid held high.
    do_xfer(0, 1'b0, 2'd1, 2'd0, 2'd2, 1'b1, 1'b0, 2'd3, 2'd0, 2'd0);
    do_xfer(0, 1'b0, 2'd3, 2'd0, 2'd0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0);

    // Reset during LATCH of a MOVE, REQ_valid held through the abort.
    valid[0] = 1'b1; op[0] = 1'b0; src[0] = 2'd0; src2[0] = 2'd0; dst[0] = 2'd3;
    @(posedge clk);
    @(negedge clk);
    check_cycle(0, 1'b0, 2'd0, 2'd0, 2'd3, 1);
    src[0] = 2'd2; dst[0] = 2'd1;
    @(negedge clk);
    check_cycle(0, 1'b0, 2'd0, 2'd0, 2'd3, 2);
    rst[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst[0] = 1'b0;
    check_idle(0, "abort");
    do_xfer(0, 1'b0, 2'd2, 2'd0, 2'd1, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0);

    // Random requests, sometimes back-to-back, sometimes with idle gaps.
    for (int k = 0; k < 2; k++) begin
      c_op = 1'(($urandom) & 1); c_s = 2'($urandom); c_s2 = 2'($urandom); c_d = 2'($urandom);
      for (int n = 0; n < 30; n++) begin
        n_op = 1'(($urandom) & 1); n_s = 2'($urandom); n_s2 = 2'($urandom); n_d = 2'($urandom);
        hold = 1'(($urandom) & 1);
        do_xfer(k, c_op, c_s, c_s2, c_d, hold, n_op, n_s, n_s2, n_d);
        if (!hold) begin
          gap = int'($urandom_range(0, 2));
          for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            check_idle(k, "gap");
          end
        end
        c_op = n_op; c_s = n_s; c_s2 = n_s2; c_d = n_d;
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
